// File: rtl/multi_line_buffer.sv
`default_nettype none
// ============================================================================
// Module      : multi_line_buffer
// Description : Multi-row raster line buffer. Delays a pixel stream by
//               1..NUM_LINES rows and presents column-aligned vertical taps
//               for window/filter blocks. Supports multi-channel pixels, a
//               runtime active width, sof/eol framing, a FILL/STREAM state
//               machine with an output-valid qualifier and sticky row-length
//               error detection.
// Optional    : MULTI_LINE_BUFFER_BORDER_REPLICATE_EN -- out_valid also high
//               during FILL; taps for rows not yet received replicate the
//               oldest available row (current pixel in the first row).
// Ports       : clk, rst          - clock, synchronous active-high reset
//               cfg_width         - active width, sampled with sof
//               pixel_in/valid    - input pixel and qualifier
//               sof, eol          - frame start / row end framing
//               out_valid/out_eol - output qualifier / delayed eol
//               out_pixel         - current pixel, one cycle later
//               line_out          - slice k = same column, k+1 rows ago
//               line_err          - sticky row-length error
// Revision    : 1.0 - initial release
// ============================================================================
module multi_line_buffer #(
  parameter int DATA_WIDTH = 8,
  parameter int CHANNELS   = 1,
  parameter int MAX_WIDTH  = 640,
  parameter int NUM_LINES  = 2
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic [$clog2(MAX_WIDTH+1)-1:0]          cfg_width,
  input  logic [CHANNELS*DATA_WIDTH-1:0]          pixel_in,
  input  logic                                    pixel_valid,
  input  logic                                    sof,
  input  logic                                    eol,
  output logic                                    out_valid,
  output logic [CHANNELS*DATA_WIDTH-1:0]          out_pixel,
  output logic [NUM_LINES*CHANNELS*DATA_WIDTH-1:0] line_out,
  output logic                                    out_eol,
  output logic                                    line_err
);

  localparam int PW = CHANNELS * DATA_WIDTH;
  localparam int WW = $clog2(MAX_WIDTH + 1);
  localparam int AW = (MAX_WIDTH > 1) ? $clog2(MAX_WIDTH) : 1;
  localparam int RW = $clog2(NUM_LINES + 1);

  localparam logic [WW-1:0] c_max_width = WW'(MAX_WIDTH);
  localparam logic [WW-1:0] c_col_one   = WW'(1);
  localparam logic [RW-1:0] c_num_lines = RW'(NUM_LINES);
  localparam logic [RW-1:0] c_row_one   = RW'(1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FILL   = 2'd1,
    STREAM = 2'd2
  } state_t;

  state_t                    state_q, state_d;
  logic [WW-1:0]             col_q, col_d;
  logic [RW-1:0]             row_q, row_d;
  logic [WW-1:0]             width_q, width_d;
  logic                      line_err_q, line_err_d;
  logic                      out_valid_q, out_valid_d;
  logic                      out_eol_q, out_eol_d;
  logic [PW-1:0]             out_pixel_q, out_pixel_d;
  logic [NUM_LINES*PW-1:0]   line_out_q, line_out_d;

  // Row storage; the RAMs are never reset, only their read data is qualified.
  logic [PW-1:0]             mem [NUM_LINES][MAX_WIDTH];
  logic [PW-1:0]             rd_data [NUM_LINES];
  logic [PW-1:0]             wr_data [NUM_LINES];
  logic [PW-1:0]             tap     [NUM_LINES];

  // Frame-relative view of the current pixel: an accepted sof restarts the
  // frame on this very pixel, so it sees col/row zero and the new width.
  logic                      accept;
  logic                      sof_acc;
  logic                      cfg_bad;
  logic [WW-1:0]             width_cur;
  logic [WW-1:0]             col_cur;
  logic [RW-1:0]             row_cur;
  state_t                    state_cur;
  logic                      last_col;
  logic                      row_end;
  logic [RW-1:0]             row_next;
  logic [AW-1:0]             addr;

  always_comb begin
    accept    = pixel_valid && ((state_q != IDLE) || sof);
    sof_acc   = pixel_valid && sof;
    cfg_bad   = (cfg_width == '0) || (cfg_width > c_max_width);
    width_cur = sof_acc ? (cfg_bad ? c_max_width : cfg_width) : width_q;
    col_cur   = sof_acc ? '0 : col_q;
    row_cur   = sof_acc ? '0 : row_q;
    state_cur = sof_acc ? FILL : state_q;
    last_col  = (col_cur == (width_cur - c_col_one));
    // Running off the end of the row without eol closes the row here so the
    // following pixel lands in column 0 of a new row.
    row_end   = eol || last_col;
    row_next  = (row_cur < c_num_lines) ? (row_cur + c_row_one) : row_cur;
    addr      = col_cur[AW-1:0];
  end

  // Read-before-write cascade: RAM k receives RAM k-1's old word at the
  // same column, so each RAM holds the row one older than its predecessor.
  always_comb begin
    for (int k = 0; k < NUM_LINES; k++) begin
      rd_data[k] = mem[k][addr];
    end
    wr_data[0] = pixel_in;
    for (int k = 1; k < NUM_LINES; k++) begin
      wr_data[k] = rd_data[k-1];
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      for (int k = 0; k < NUM_LINES; k++) begin
        mem[k][addr] <= wr_data[k];
      end
    end
  end

`ifdef MULTI_LINE_BUFFER_BORDER_REPLICATE_EN
  logic [RW-1:0] oldest_idx;

  // During FILL only row_cur older rows exist; deeper taps reuse the oldest.
  always_comb begin
    oldest_idx = row_cur - c_row_one;
    for (int k = 0; k < NUM_LINES; k++) begin
      tap[k] = rd_data[k];
      if ((state_cur == FILL) && (k >= int'(row_cur))) begin
        tap[k] = (row_cur == '0) ? pixel_in : rd_data[oldest_idx];
      end
    end
  end
`else
  always_comb begin
    for (int k = 0; k < NUM_LINES; k++) begin
      tap[k] = rd_data[k];
    end
  end
`endif

  always_comb begin
    state_d     = state_q;
    col_d       = col_q;
    row_d       = row_q;
    width_d     = width_q;
    line_err_d  = line_err_q;
    out_valid_d = 1'b0;
    out_eol_d   = 1'b0;
    out_pixel_d = out_pixel_q;
    line_out_d  = line_out_q;

    if (accept) begin
      width_d = width_cur;
      state_d = state_cur;
      if (row_end) begin
        col_d = '0;
        row_d = row_next;
        if ((state_cur == FILL) && (row_next == c_num_lines)) begin
          state_d = STREAM;
        end
      end else begin
        col_d = col_cur + c_col_one;
        row_d = row_cur;
      end

      // A row is well formed only when eol and the last column coincide.
      line_err_d = (sof_acc ? 1'b0 : line_err_q)
                 | (sof_acc && cfg_bad)
                 | (eol != last_col);

`ifdef MULTI_LINE_BUFFER_BORDER_REPLICATE_EN
      out_valid_d = (state_cur == FILL) || (state_cur == STREAM);
`else
      out_valid_d = (state_cur == STREAM);
`endif
      out_eol_d   = eol;
      out_pixel_d = pixel_in;
      for (int k = 0; k < NUM_LINES; k++) begin
        line_out_d[k*PW +: PW] = tap[k];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      col_q       <= '0;
      row_q       <= '0;
      width_q     <= '0;
      line_err_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_eol_q   <= 1'b0;
      out_pixel_q <= '0;
      line_out_q  <= '0;
    end else begin
      state_q     <= state_d;
      col_q       <= col_d;
      row_q       <= row_d;
      width_q     <= width_d;
      line_err_q  <= line_err_d;
      out_valid_q <= out_valid_d;
      out_eol_q   <= out_eol_d;
      out_pixel_q <= out_pixel_d;
      line_out_q  <= line_out_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_eol   = out_eol_q;
  assign out_pixel = out_pixel_q;
  assign line_out  = line_out_q;
  assign line_err  = line_err_q;

endmodule
`default_nettype wire

// File: tb/tb_multi_line_buffer.sv
`default_nettype none
// ============================================================================
// Module      : tb_multi_line_buffer
// Description : Directed self-checking bench for multi_line_buffer. Drives a
//               single-channel and a 3-channel instance with the same raster
//               and compares against hand-derived expected values.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_multi_line_buffer;

`ifdef MULTI_LINE_BUFFER_BORDER_REPLICATE_EN
  localparam bit REPL = 1'b1;
`else
  localparam bit REPL = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [9:0]  cfg_width;
  logic [7:0]  pixel_in;
  logic [23:0] pixel3;
  logic        pixel_valid, sof, eol;

  logic        out_valid, out_eol, line_err;
  logic [7:0]  out_pixel;
  logic [15:0] line_out;
  logic        out_valid3, out_eol3, line_err3;
  logic [23:0] out_pixel3;
  logic [47:0] line_out3;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  multi_line_buffer u_dut (
    .clk(clk), .rst(rst), .cfg_width(cfg_width), .pixel_in(pixel_in),
    .pixel_valid(pixel_valid), .sof(sof), .eol(eol),
    .out_valid(out_valid), .out_pixel(out_pixel), .line_out(line_out),
    .out_eol(out_eol), .line_err(line_err)
  );

  multi_line_buffer #(.CHANNELS(3)) u_dut3 (
    .clk(clk), .rst(rst), .cfg_width(cfg_width), .pixel_in(pixel3),
    .pixel_valid(pixel_valid), .sof(sof), .eol(eol),
    .out_valid(out_valid3), .out_pixel(out_pixel3), .line_out(line_out3),
    .out_eol(out_eol3), .line_err(line_err3)
  );

  // Expected tap k for pixel j of a width-10 frame whose pixels are base+j.
  // Before enough rows exist the oldest available row (or the pixel) is used.
  function automatic int exp_tap(input int base, input int j, input int k);
    int r;
    int n;
    r = j / 10;
    if (r == 0) return base + j;
    n = (k + 1 < r) ? k + 1 : r;
    return base + j - 10 * n;
  endfunction

  // Apply one input cycle; outputs are sampled 1 time unit after the edge.
  task automatic step(input int p, input logic s, input logic e, input logic v);
    pixel_in    = 8'(p);
    pixel3      = {8'(p + 2), 8'(p + 1), 8'(p)};
    sof         = s;
    eol         = e;
    pixel_valid = v;
    @(posedge clk);
    #1;
    pixel_valid = 1'b0;
    sof         = 1'b0;
    eol         = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step(5, 1'b1, 1'b0, 1'b1);
    step(6, 1'b0, 1'b0, 1'b1);
    checks++;
    if ({out_valid, out_eol, line_err, out_pixel, line_out} !== 27'd0) begin
      errors++;
      $display("FAIL reset_outputs got %h want 0", {out_valid, out_eol, line_err, out_pixel, line_out});
    end
    checks++;
    if ({out_valid3, out_pixel3, line_out3} !== 73'd0) begin
      errors++;
      $display("FAIL reset_outputs3 got %h want 0", {out_valid3, out_pixel3, line_out3});
    end
    rst = 1'b0;
    // Idle: pixels without sof are ignored.
    for (int i = 0; i < 3; i++) begin
      step(40 + i, 1'b0, 1'b0, 1'b1);
      checks++;
      if (out_valid !== 1'b0 || out_pixel !== 8'd0) begin
        errors++;
        $display("FAIL idle_ignore got valid=%b pix=%0d want 0/0", out_valid, out_pixel);
      end
    end
  endtask

  task automatic test_stream();
    int nvalid = 0;
    bit exp_v;
    cfg_width = 10'd10;
    for (int p = 0; p < 50; p++) begin
      step(p, p == 0, (p % 10) == 9, 1'b1);
      exp_v = REPL || (p >= 20);
      if (out_valid) nvalid++;
      checks++;
      if (out_valid !== exp_v || out_pixel !== 8'(p) || out_eol !== ((p % 10) == 9)) begin
        errors++;
        $display("FAIL stream_ctl p=%0d got v=%b pix=%0d eol=%b want v=%b", p, out_valid, out_pixel, out_eol, exp_v);
      end
      if (exp_v) begin
        for (int k = 0; k < 2; k++) begin
          checks++;
          if (line_out[k*8 +: 8] !== 8'(exp_tap(0, p, k))) begin
            errors++;
            $display("FAIL stream_tap p=%0d k=%0d got %0d want %0d", p, k, line_out[k*8 +: 8], exp_tap(0, p, k));
          end
          for (int ch = 0; ch < 3; ch++) begin
            checks++;
            if (line_out3[(k*3+ch)*8 +: 8] !== 8'(exp_tap(0, p, k) + ch)) begin
              errors++;
              $display("FAIL chan_tap p=%0d k=%0d ch=%0d got %0d want %0d", p, k, ch, line_out3[(k*3+ch)*8 +: 8], exp_tap(0, p, k) + ch);
            end
          end
        end
      end
    end
    checks++;
    if (nvalid !== (REPL ? 50 : 30)) begin
      errors++;
      $display("FAIL stream_count got %0d want %0d", nvalid, REPL ? 50 : 30);
    end
  endtask

  task automatic test_gaps();
    int p = 0;
    int guard = 0;
    bit exp_v;
    cfg_width = 10'd10;
    while (p < 50 && guard < 400) begin
      guard++;
      if (p > 0 && $urandom_range(0, 1) == 0) begin
        step(200, 1'b1, 1'b1, 1'b0);
        checks++;
        if (out_valid !== 1'b0 || out_eol !== 1'b0 || out_pixel !== 8'(p - 1)) begin
          errors++;
          $display("FAIL gap_hold got v=%b eol=%b pix=%0d want 0/0/%0d", out_valid, out_eol, out_pixel, p - 1);
        end
      end else begin
        step(p, p == 0, (p % 10) == 9, 1'b1);
        exp_v = REPL || (p >= 20);
        checks++;
        if (out_valid !== exp_v || out_pixel !== 8'(p)) begin
          errors++;
          $display("FAIL gap_ctl p=%0d got v=%b pix=%0d want v=%b", p, out_valid, out_pixel, exp_v);
        end
        if (exp_v) begin
          checks++;
          if (line_out !== {8'(exp_tap(0, p, 1)), 8'(exp_tap(0, p, 0))}) begin
            errors++;
            $display("FAIL gap_tap p=%0d got %h want %h", p, line_out, {8'(exp_tap(0, p, 1)), 8'(exp_tap(0, p, 0))});
          end
        end
        p++;
      end
    end
  endtask

  task automatic test_line_err();
    cfg_width = 10'd10;
    for (int p = 0; p < 27; p++) begin
      step(p, p == 0, (p % 10) == 9, 1'b1);
    end
    checks++;
    if (line_err !== 1'b0) begin
      errors++;
      $display("FAIL err_before got %b want 0", line_err);
    end
    step(27, 1'b0, 1'b1, 1'b1);  // eol at column 7 of row 2
    checks++;
    if (line_err !== 1'b1 || out_eol !== 1'b1 || out_pixel !== 8'd27 || line_out[7:0] !== 8'd17) begin
      errors++;
      $display("FAIL err_short got err=%b eol=%b pix=%0d tap0=%0d want 1/1/27/17", line_err, out_eol, out_pixel, line_out[7:0]);
    end
    for (int p = 28; p < 38; p++) begin
      step(p, 1'b0, p == 37, 1'b1);
      if (p == 28) begin
        checks++;
        if (line_out !== {8'd10, 8'd20}) begin
          errors++;
          $display("FAIL err_realign got %h want 0a14", line_out);
        end
      end
    end
    checks++;
    if (line_err !== 1'b1) begin
      errors++;
      $display("FAIL err_sticky got %b want 1", line_err);
    end
    step(0, 1'b1, 1'b0, 1'b1);
    checks++;
    if (line_err !== 1'b0) begin
      errors++;
      $display("FAIL err_clear_sof got %b want 0", line_err);
    end
    cfg_width = 10'd0;
    step(0, 1'b1, 1'b0, 1'b1);
    checks++;
    if (line_err !== 1'b1) begin
      errors++;
      $display("FAIL clamp_zero got %b want 1", line_err);
    end
    cfg_width = 10'd641;
    step(0, 1'b1, 1'b0, 1'b1);
    checks++;
    if (line_err !== 1'b1) begin
      errors++;
      $display("FAIL clamp_big got %b want 1", line_err);
    end
    cfg_width = 10'd1;
    step(1, 1'b1, 1'b1, 1'b1);
    checks++;
    if (line_err !== 1'b0) begin
      errors++;
      $display("FAIL one_pix_w1 got %b want 0", line_err);
    end
    cfg_width = 10'd10;
    step(1, 1'b1, 1'b1, 1'b1);
    checks++;
    if (line_err !== 1'b1) begin
      errors++;
      $display("FAIL one_pix_w10 got %b want 1", line_err);
    end
    cfg_width = 10'd4;
    for (int p = 0; p < 3; p++) step(p, p == 0, 1'b0, 1'b1);
    checks++;
    if (line_err !== 1'b0) begin
      errors++;
      $display("FAIL overrun_early got %b want 0", line_err);
    end
    step(3, 1'b0, 1'b0, 1'b1);
    step(4, 1'b0, 1'b0, 1'b1);
    checks++;
    if (line_err !== 1'b1) begin
      errors++;
      $display("FAIL overrun got %b want 1", line_err);
    end
  endtask

  task automatic test_restart();
    bit exp_v;
    cfg_width = 10'd10;
    for (int p = 0; p < 25; p++) step(p, p == 0, (p % 10) == 9, 1'b1);
    for (int j = 0; j < 30; j++) begin
      step(100 + j, j == 0, (j % 10) == 9, 1'b1);
      exp_v = REPL || (j >= 20);
      checks++;
      if (out_valid !== exp_v || out_pixel !== 8'(100 + j)) begin
        errors++;
        $display("FAIL restart_ctl j=%0d got v=%b pix=%0d want v=%b", j, out_valid, out_pixel, exp_v);
      end
      if (exp_v) begin
        checks++;
        if (line_out !== {8'(exp_tap(100, j, 1)), 8'(exp_tap(100, j, 0))}) begin
          errors++;
          $display("FAIL restart_tap j=%0d got %h want %h", j, line_out, {8'(exp_tap(100, j, 1)), 8'(exp_tap(100, j, 0))});
        end
      end
    end
    for (int p = 0; p < 5; p++) step(60 + p, p == 0, 1'b0, 1'b1);
    rst = 1'b1;
    step(77, 1'b0, 1'b1, 1'b1);
    rst = 1'b0;
    checks++;
    if ({out_valid, out_eol, line_err, out_pixel, line_out} !== 27'd0) begin
      errors++;
      $display("FAIL midrow_rst got %h want 0", {out_valid, out_eol, line_err, out_pixel, line_out});
    end
    for (int p = 0; p < 3; p++) begin
      step(50, 1'b0, 1'b0, 1'b1);
      checks++;
      if (out_valid !== 1'b0 || out_pixel !== 8'd0 || line_out !== 16'd0) begin
        errors++;
        $display("FAIL post_rst_idle got v=%b pix=%0d taps=%h want 0", out_valid, out_pixel, line_out);
      end
    end
  endtask

  initial begin
    rst         = 1'b1;
    cfg_width   = 10'd10;
    pixel_in    = 8'd0;
    pixel3      = 24'd0;
    pixel_valid = 1'b0;
    sof         = 1'b0;
    eol         = 1'b0;
    @(posedge clk);
    #1;
    test_reset();
    test_stream();
    test_gaps();
    test_line_err();
    test_restart();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
